cmp_share_arbiter: RTL and testbench
====================================

Name: cmp_share_arbiter

Overview:
- Round-robin controller that shares one external combinational 32-bit less-than comparator among NUM_REQ requesters.
- Each requester presents an operand pair and a level request. The block grants one requester at a time, registers its operands onto the comparator inputs, and gives the comparator a full cycle to settle. It then captures the result and returns it with a one-cycle response pulse.
- Sits between execute-stage consumers (branch compare, slt-style ops, sort helper) and the single shared comparator instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand width; must match the comparator.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request per requester; held until the matching rsp_valid bit.
- a_in  input  NUM_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]; stable while req[i] is high.
- b_in  input  NUM_REQ*WIDTH  operand B; same packing as a_in.
- gnt  output  NUM_REQ  one-hot owner of the comparator, high in EVAL and DONE.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse carrying the result to the owner.
- rsp_lt  output  1  captured comparator result; holds until the next capture.
- busy  output  1  high whenever state is not IDLE.
- cmp_a  output  WIDTH  registered operand A to the comparator.
- cmp_b  output  WIDTH  registered operand B to the comparator.
- cmp_lt  input  1  comparator result, combinational from cmp_a and cmp_b.

Behaviour:
- Reset:
  - state=IDLE, gnt=0, rsp_valid=0, rsp_lt=0, busy=0, cmp_a=0, cmp_b=0.
  - Owner register = 0; round-robin pointer = 0.
  - Reset mid-operation aborts the operation with no rsp_valid pulse.
- FSM: IDLE -> EVAL -> DONE -> IDLE, three cycles per operation.
- IDLE:
  - If req != 0, select the winner: the first set req bit scanning upward from the pointer, wrapping modulo NUM_REQ.
  - Latch the winner's operands into cmp_a/cmp_b and its index into the owner register, then go to EVAL.
  - If req == 0, stay in IDLE; cmp_a/cmp_b hold their previous values.
- EVAL:
  - gnt[owner]=1; the comparator settles.
  - At the end of the cycle, rsp_lt <= cmp_lt; go to DONE.
- DONE:
  - rsp_valid[owner]=1 for exactly this cycle; gnt[owner] stays 1.
  - Pointer <= (owner+1) mod NUM_REQ; go to IDLE.
- Latency: req first seen in IDLE at cycle T gives gnt in T+1..T+2 and rsp_valid/rsp_lt in T+2.
- Throughput: one compare per 3 cycles.
- Fairness: a continuously held request is served within NUM_REQ operations.
- Re-request: a requester may keep req high after its rsp_valid to ask for another compare. It is treated as a new request and arbitrated in the following IDLE.
- Request dropped after grant: the operation still completes and rsp_valid still pulses; the requester ignores it.
- Operand changes after the IDLE sampling edge have no effect on the in-flight result.
- cmp_lt is passed through unmodified; signedness is defined by the comparator, not this block.

Optional Feature:
- Macro: CMP_SHARE_PERF_EN.
- Defined:
  - Adds outputs perf_ops (32-bit) and perf_wait (32-bit).
  - perf_ops increments on every DONE cycle.
  - perf_wait increments on every cycle in which some req bit is high but that requester is neither owner nor being accepted this cycle.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single compare: req=0001 with a0=5, b0=9, comparator model lt=1 -> gnt=0001 in cycles 1-2, rsp_valid=0001 only in cycle 2, rsp_lt=1; busy=0 in cycle 3.
- All requests held: req=1111 from cycle 0 -> rsp_valid order 0,1,2,3,0 at cycles 2,5,8,11,14; gnt never has more than one bit set.
- Pointer wrap: after serving req1, pointer=2; assert req=1001 -> requester 3 served first, then 0.
- Reset mid-operation: assert reset during EVAL -> next cycle IDLE, gnt=0, no rsp_valid pulse; a following req=0100 is served ahead of lower indices (scan from pointer=0 finds bit 2 first).
- Operand isolation: a0=0xFFFFFFFF, b0=0xFFFFFFFF sampled, then a0 changed to 0 during EVAL -> cmp_a stays 0xFFFFFFFF; rsp_lt equals the model output for equal operands (0).
- With CMP_SHARE_PERF_EN defined, req=0011 held for 2 ops -> perf_ops=2; perf_wait counts requester 1's waiting cycles: 3 (cycles 0-2).

Source files
------------

// File: rtl/cmp_share_arbiter_if.sv
// Request/response and comparator-side bundle for cmp_share_arbiter.
// The master side belongs to the requesters and the comparator; the slave side belongs to the arbiter.
interface cmp_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic                     rsp_lt;
  logic                     busy;
  logic [WIDTH-1:0]         cmp_a;
  logic [WIDTH-1:0]         cmp_b;
  logic                     cmp_lt;

  modport master (
    output req, a_in, b_in, cmp_lt,
    input  gnt, rsp_valid, rsp_lt, busy, cmp_a, cmp_b
  );

  modport slave (
    input  req, a_in, b_in, cmp_lt,
    output gnt, rsp_valid, rsp_lt, busy, cmp_a, cmp_b
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin sharing of one external combinational less-than comparator (IDLE -> EVAL -> DONE).
// Optional CMP_SHARE_PERF_EN adds perf_ops / perf_wait counters.
module cmp_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  cmp_share_arbiter_if.slave   bus
`ifdef CMP_SHARE_PERF_EN
  ,
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_wait
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_lt_q, rsp_lt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   cmp_a_q, cmp_a_d;
  logic [WIDTH-1:0]   cmp_b_q, cmp_b_d;

  logic [WIDTH-1:0]   a_arr_s [NUM_REQ];
  logic [WIDTH-1:0]   b_arr_s [NUM_REQ];
  logic [IDX_W-1:0]   scan_idx_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               win_found_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr_s[g] = bus.a_in[g*WIDTH +: WIDTH];
    assign b_arr_s[g] = bus.b_in[g*WIDTH +: WIDTH];
  end

  // First set request scanning upward from the pointer, wrapping.
  always_comb begin
    scan_idx_s  = '0;
    win_idx_s   = '0;
    win_found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found_s && bus.req[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output logic for the three-phase operation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_lt_d    = rsp_lt_q;
    busy_d      = busy_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_EVAL;
          owner_d = win_idx_s;
          cmp_a_d = a_arr_s[win_idx_s];
          cmp_b_d = b_arr_s[win_idx_s];
          gnt_d   = ONE_HOT0 << win_idx_s;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      ST_EVAL: begin
        // Operands have been stable on the comparator for a full cycle here.
        state_d     = ST_DONE;
        rsp_lt_d    = bus.cmp_lt;
        rsp_valid_d = ONE_HOT0 << owner_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_lt_q    <= 1'b0;
      busy_q      <= 1'b0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lt_q    <= rsp_lt_d;
      busy_q      <= busy_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_lt    = rsp_lt_q;
  assign bus.busy      = busy_q;
  assign bus.cmp_a     = cmp_a_q;
  assign bus.cmp_b     = cmp_b_q;

`ifdef CMP_SHARE_PERF_EN
  logic [31:0]        perf_ops_q, perf_ops_d;
  logic [31:0]        perf_wait_q, perf_wait_d;
  logic [NUM_REQ-1:0] accept_s;
  logic               wait_s;

  // Owner is gnt_q (valid only outside IDLE); the requester being accepted is gnt_d in IDLE.
  always_comb begin
    accept_s    = (state_q == ST_IDLE) ? gnt_d : '0;
    wait_s      = |(bus.req & ~gnt_q & ~accept_s);
    perf_ops_d  = (state_q == ST_DONE) ? perf_ops_q + 32'd1 : perf_ops_q;
    perf_wait_d = wait_s ? perf_wait_q + 32'd1 : perf_wait_q;
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_ops_q  <= 32'd0;
      perf_wait_q <= 32'd0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_wait = perf_wait_q;
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: a transaction-level round-robin model predicts each
// response; a monitor pops and compares whenever rsp_valid is seen.
module tb_cmp_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmp_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus();
  assign bus.cmp_lt = (bus.cmp_a < bus.cmp_b);

`ifdef CMP_SHARE_PERF_EN
  logic [31:0] perf_ops, perf_wait;
`endif

  cmp_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
`ifdef CMP_SHARE_PERF_EN
    ,
    .perf_ops  (perf_ops),
    .perf_wait (perf_wait)
`endif
  );

  typedef struct {
    logic [N-1:0] mask;
    logic         lt;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           m_ptr = 0;
  int           m_free = 0;
  int           m_acc = -10;
  int           m_owner = 0;
  logic [N-1:0] hold_v = '0;
  logic [W-1:0] ext_v [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  task automatic set_ops(int i, logic [W-1:0] a, logic [W-1:0] b);
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
  endtask

  task automatic rand_ops(int i);
    logic [W-1:0] a, b;
    case ($urandom_range(0, 3))
      0: begin a = $urandom; b = $urandom; end
      1: begin a = $urandom; b = a; end
      2: begin a = ext_v[$urandom_range(0, 3)]; b = ext_v[$urandom_range(0, 3)]; end
      default: begin b = $urandom; a = ($urandom_range(0, 1) == 0) ? b + 32'd1 : b - 32'd1; end
    endcase
    set_ops(i, a, b);
  endtask

  // Reference model: one acceptance at most every three cycles, winner by round-robin scan.
  task automatic commit();
    int w;
    exp_t e;
    if (rst) begin
      sb.delete();
      m_ptr = 0;
      m_free = cyc + 1;
      m_acc = -10;
    end else if (cyc >= m_free && bus.req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      e.mask = N'(1) << w;
      e.a    = bus.a_in[w*W +: W];
      e.b    = bus.b_in[w*W +: W];
      e.lt   = (e.a < e.b);
      e.due  = cyc + 2;
      sb.push_back(e);
      m_acc   = cyc;
      m_owner = w;
      m_ptr   = (w + 1) % N;
      m_free  = cyc + 3;
    end
  endtask

  // Requesters drop after their response unless they hold for a fresh compare.
  task automatic next_cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (bus.rsp_valid[i]) begin
        if (hold_v[i]) rand_ops(i);
        else bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      next_cycle();
      commit();
    end
  endtask

  task automatic pulse_reset();
    next_cycle(); rst = 1'b1; bus.req = '0; hold_v = '0; commit();
    next_cycle(); commit();
    next_cycle(); rst = 1'b0; commit();
  endtask

  // Monitor: cycle-level gnt/busy plus scoreboard pop on every response pulse.
  initial begin
    logic [N-1:0] eg;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      eg = (cyc == m_acc + 1 || cyc == m_acc + 2) ? (N'(1) << m_owner) : '0;
      check("gnt", 64'(bus.gnt), 64'(eg));
      check("busy", 64'(bus.busy), 64'(eg != '0));
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("rsp_missing", 64'(0), 64'(sb[0].mask));
        void'(sb.pop_front());
      end
      if (bus.rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_valid", 64'(bus.rsp_valid), 64'(e.mask));
          check("rsp_cycle", 64'(cyc), 64'(e.due));
          check("rsp_lt", 64'(bus.rsp_lt), 64'(e.lt));
          check("cmp_a", 64'(bus.cmp_a), 64'(e.a));
          check("cmp_b", 64'(bus.cmp_b), 64'(e.b));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    run(3);
    check("reset_cmp_a", 64'(bus.cmp_a), 64'(0));
    check("reset_cmp_b", 64'(bus.cmp_b), 64'(0));
    check("reset_rsp_lt", 64'(bus.rsp_lt), 64'(0));
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));

`ifdef CMP_SHARE_PERF_EN
    next_cycle(); rst = 1'b0;
    set_ops(0, 32'd1, 32'd2); set_ops(1, 32'd3, 32'd2);
    bus.req = 4'b0011; commit();
    run(8);
    check("perf_ops", 64'(perf_ops), 64'(2));
    check("perf_wait", 64'(perf_wait), 64'(3));
`endif

    // Single compare 5 < 9.
    pulse_reset();
    next_cycle(); set_ops(0, 32'd5, 32'd9); bus.req = 4'b0001; commit();
    run(4);

    // All requests held continuously: order 0,1,2,3,0.
    hold_v = 4'hF;
    next_cycle(); for (int i = 0; i < N; i++) rand_ops(i); bus.req = 4'hF; commit();
    run(14);
    hold_v = 4'h0;
    run(15);

    // Pointer wrap: serve 1, then 1001 gives 3 before 0.
    pulse_reset();
    next_cycle(); set_ops(1, 32'd7, 32'd7); bus.req = 4'b0010; commit();
    run(5);
    next_cycle(); set_ops(0, 32'd1, 32'd0); set_ops(3, 32'd0, 32'd1); bus.req = 4'b1001; commit();
    run(8);

    // Reset during EVAL aborts; 0100 then wins from pointer 0.
    pulse_reset();
    next_cycle(); set_ops(0, 32'd2, 32'd3); bus.req = 4'b0001; commit();
    next_cycle(); rst = 1'b1; commit();
    next_cycle(); rst = 1'b0; set_ops(2, 32'd9, 32'd4); bus.req = 4'b0100; commit();
    run(5);

    // Operand change after sampling does not reach the comparator.
    next_cycle(); set_ops(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); bus.req = 4'b0001; commit();
    next_cycle(); set_ops(0, 32'h0, 32'hFFFF_FFFF); commit();
    run(4);

    // Randomized traffic with re-requests, drops after grant and occasional resets.
    repeat (3000) begin
      next_cycle();
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 15) == 0) hold_v = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          rand_ops(i);
          bus.req[i] = 1'b1;
        end else if (bus.req[i] && bus.gnt[i] && !bus.rsp_valid[i] && $urandom_range(0, 19) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      commit();
    end

    next_cycle(); rst = 1'b0; bus.req = '0; hold_v = '0; commit();
    run(10);
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
